// File: rtl/rx_eth_frame_writer_pkg.sv
// Shared constants, FSM encoding and header helper for the RX Ethernet frame writer.
package rx_eth_frame_writer_pkg;

    localparam int BF_DEFAULT        = 8;
    localparam int MAX_BEATS_DEFAULT = 191;
    localparam int DATA_W            = 64;
    localparam int KEEP_W            = 8;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 15;

    // One-hot so a single-bit upset lands in the default recovery arm.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_RECV   = 5'b00010,
        ST_HDR    = 5'b00100,
        ST_COMMIT = 5'b01000,
        ST_DROP   = 5'b10000
    } state_t;

    function automatic logic [DATA_W-1:0] make_header(input logic [15:0] byte_len);
        logic [DATA_W-1:0] hdr;
        hdr = {DATA_W{1'b0}};
        hdr[HDR_LEN_MSB:HDR_LEN_LSB] = byte_len;
        return hdr;
    endfunction

endpackage

// File: rtl/rx_eth_frame_writer_if.sv
// AXI-stream receive bus from the 10G MAC (no backpressure, so no tready).
interface rx_eth_frame_writer_if;
    import rx_eth_frame_writer_pkg::*;

    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser);
    modport slave  (input  tdata, tkeep, tvalid, tlast, tuser);
endinterface

// File: rtl/rx_tkeep_popcount.sv
// Converts a contiguous tkeep mask into a byte count of 0..8.
module rx_tkeep_popcount (
    input  logic [7:0] tkeep,
    output logic [3:0] byte_count
);

    // Contiguous masks decode directly; anything else falls back to a plain bit count.
    always_comb begin
        byte_count = 4'd0;
        case (tkeep)
            8'h00: byte_count = 4'd0;
            8'h01: byte_count = 4'd1;
            8'h03: byte_count = 4'd2;
            8'h07: byte_count = 4'd3;
            8'h0F: byte_count = 4'd4;
            8'h1F: byte_count = 4'd5;
            8'h3F: byte_count = 4'd6;
            8'h7F: byte_count = 4'd7;
            8'hFF: byte_count = 4'd8;
            default: begin
                for (int i = 0; i < 8; i++) begin
                    byte_count = byte_count + {3'd0, tkeep[i]};
                end
            end
        endcase
    end

endmodule

// File: rtl/rx_eth_frame_writer.sv
// Packs MAC frames into the RX circular buffer as qwords plus one length header,
// publishing commited_wr_address only once a complete good frame is stored.
module rx_eth_frame_writer
    import rx_eth_frame_writer_pkg::*;
#(
    parameter int BF        = BF_DEFAULT,
    parameter int MAX_BEATS = MAX_BEATS_DEFAULT
) (
    input  logic                   clk156,
    input  logic                   reset,
    rx_eth_frame_writer_if.slave   rx_axis,
    input  logic [BF:0]            commited_rd_address,
    output logic [BF:0]            wr_addr,
    output logic [DATA_W-1:0]      wr_data,
    output logic                   wr_en,
    output logic [BF:0]            commited_wr_address,
    output logic [31:0]            accepted_frames,
    output logic [31:0]            dropped_frames
);

    localparam logic [BF:0] PTR_ZERO    = {(BF+1){1'b0}};
    localparam logic [BF:0] PTR_ONE     = {{BF{1'b0}}, 1'b1};
    localparam logic [BF:0] PTR_TWO     = {{(BF-1){1'b0}}, 2'b10};
    localparam logic [15:0] MAX_BEATS_W = 16'(MAX_BEATS);

    state_t            state_r, state_s;
    logic [BF:0]       rd_reg_r;
    logic [BF:0]       cur_ptr_r, cur_ptr_s;
    logic [BF:0]       frame_start_r, frame_start_s;
    logic [15:0]       beats_r, beats_s;
    logic [3:0]        last_cnt_r, last_cnt_s;
    logic              gap_viol_r, gap_viol_s;
    logic [BF:0]       commit_s;
    logic [31:0]       accepted_s, dropped_s;
    logic              wr_en_s;
    logic [BF:0]       wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic [BF:0]       free_s;
    logic [3:0]        keep_cnt_s;
    logic [15:0]       frame_len_s;

    rx_tkeep_popcount u_popcount (
        .tkeep      (rx_axis.tkeep),
        .byte_count (keep_cnt_s)
    );

    // One slot is always kept empty so a full buffer never looks empty to the reader.
    assign free_s      = rd_reg_r - cur_ptr_r - PTR_ONE;
    assign frame_len_s = ((beats_r - 16'd1) << 3) + {12'd0, last_cnt_r};

    // Next-state, pointer, counter and write-port logic.
    always_comb begin
        state_s       = state_r;
        cur_ptr_s     = cur_ptr_r;
        frame_start_s = frame_start_r;
        beats_s       = beats_r;
        last_cnt_s    = last_cnt_r;
        gap_viol_s    = gap_viol_r;
        commit_s      = commited_wr_address;
        accepted_s    = accepted_frames;
        dropped_s     = dropped_frames;
        wr_en_s       = 1'b0;
        wr_addr_s     = wr_addr;
        wr_data_s     = wr_data;

        case (state_r)
            ST_IDLE: begin
                if (rx_axis.tvalid) begin
                    if (free_s >= PTR_TWO) begin
                        if (rx_axis.tlast && !rx_axis.tuser) begin
                            dropped_s = dropped_frames + 32'd1;
                        end else begin
                            // Slot at cur_ptr is reserved for the header.
                            frame_start_s = cur_ptr_r;
                            wr_en_s       = 1'b1;
                            wr_addr_s     = cur_ptr_r + PTR_ONE;
                            wr_data_s     = rx_axis.tdata;
                            cur_ptr_s     = cur_ptr_r + PTR_TWO;
                            beats_s       = 16'd1;
                            last_cnt_s    = keep_cnt_s;
                            state_s       = rx_axis.tlast ? ST_HDR : ST_RECV;
                        end
                    end else if (rx_axis.tlast) begin
                        dropped_s = dropped_frames + 32'd1;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_RECV: begin
                if (rx_axis.tvalid) begin
                    if ((free_s != PTR_ZERO) && (beats_r < MAX_BEATS_W)) begin
                        wr_en_s    = 1'b1;
                        wr_addr_s  = cur_ptr_r;
                        wr_data_s  = rx_axis.tdata;
                        cur_ptr_s  = cur_ptr_r + PTR_ONE;
                        beats_s    = beats_r + 16'd1;
                        last_cnt_s = keep_cnt_s;
                        if (rx_axis.tlast) begin
                            if (rx_axis.tuser) begin
                                state_s = ST_HDR;
                            end else begin
                                dropped_s = dropped_frames + 32'd1;
                                cur_ptr_s = commited_wr_address;
                                state_s   = ST_IDLE;
                            end
                        end else begin
                            state_s = ST_RECV;
                        end
                    end else begin
                        cur_ptr_s = commited_wr_address;
                        if (rx_axis.tlast) begin
                            dropped_s = dropped_frames + 32'd1;
                            state_s   = ST_IDLE;
                        end else begin
                            state_s = ST_DROP;
                        end
                    end
                end else begin
                    state_s = ST_RECV;
                end
            end

            ST_HDR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = frame_start_r;
                wr_data_s = make_header(frame_len_s);
                state_s   = ST_COMMIT;
                // A frame starting this early broke the inter-frame gap and is discarded.
                if (rx_axis.tvalid) begin
                    if (rx_axis.tlast) begin
                        dropped_s = dropped_frames + 32'd1;
                    end else begin
                        gap_viol_s = 1'b1;
                    end
                end else begin
                    gap_viol_s = gap_viol_r;
                end
            end

            ST_COMMIT: begin
                commit_s   = cur_ptr_r;
                accepted_s = accepted_frames + 32'd1;
                gap_viol_s = 1'b0;
                if (rx_axis.tvalid && rx_axis.tlast) begin
                    dropped_s = dropped_frames + 32'd1;
                    state_s   = ST_IDLE;
                end else if (rx_axis.tvalid || gap_viol_r) begin
                    state_s = ST_DROP;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (rx_axis.tvalid && rx_axis.tlast) begin
                    dropped_s = dropped_frames + 32'd1;
                    state_s   = ST_IDLE;
                end else begin
                    state_s = ST_DROP;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                cur_ptr_s  = commited_wr_address;
                gap_viol_s = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and write-port registers.
    always_ff @(posedge clk156) begin
        if (reset) begin
            state_r             <= ST_IDLE;
            rd_reg_r            <= PTR_ZERO;
            cur_ptr_r           <= PTR_ZERO;
            frame_start_r       <= PTR_ZERO;
            beats_r             <= 16'd0;
            last_cnt_r          <= 4'd0;
            gap_viol_r          <= 1'b0;
            commited_wr_address <= PTR_ZERO;
            accepted_frames     <= 32'd0;
            dropped_frames      <= 32'd0;
            wr_en               <= 1'b0;
            wr_addr             <= PTR_ZERO;
            wr_data             <= {DATA_W{1'b0}};
        end else begin
            state_r             <= state_s;
            rd_reg_r            <= commited_rd_address;
            cur_ptr_r           <= cur_ptr_s;
            frame_start_r       <= frame_start_s;
            beats_r             <= beats_s;
            last_cnt_r          <= last_cnt_s;
            gap_viol_r          <= gap_viol_s;
            commited_wr_address <= commit_s;
            accepted_frames     <= accepted_s;
            dropped_frames      <= dropped_s;
            wr_en               <= wr_en_s;
            wr_addr             <= wr_addr_s;
            wr_data             <= wr_data_s;
        end
    end

endmodule

// File: tb/tb_rx_eth_frame_writer.sv
// Scoreboard bench: expected committed frames are queued as stimulus is driven and
// checked (commit pointer, counter, header and data qwords) when the commit moves.
module tb_rx_eth_frame_writer;
    import rx_eth_frame_writer_pkg::*;

    localparam int BF   = 8;
    localparam int MAXB = 191;

    typedef struct {
        logic [BF:0] hdr;
        logic [15:0] len;
        int          n;
        int          seed;
        logic [BF:0] commit;
        logic [31:0] acc;
    } sb_t;

    logic              clk156 = 1'b0;
    logic              reset;
    logic [BF:0]       commited_rd_address;
    logic [BF:0]       wr_addr;
    logic [63:0]       wr_data;
    logic              wr_en;
    logic [BF:0]       commited_wr_address;
    logic [31:0]       accepted_frames;
    logic [31:0]       dropped_frames;

    rx_eth_frame_writer_if rx_axis ();

    rx_eth_frame_writer #(.BF(BF), .MAX_BEATS(MAXB)) dut (
        .clk156              (clk156),
        .reset               (reset),
        .rx_axis             (rx_axis),
        .commited_rd_address (commited_rd_address),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_en               (wr_en),
        .commited_wr_address (commited_wr_address),
        .accepted_frames     (accepted_frames),
        .dropped_frames      (dropped_frames)
    );

    always #3 clk156 = ~clk156;

    int          err_cnt = 0;
    int          chk_cnt = 0;
    sb_t         sb_q[$];
    logic [63:0] mem [0:(1<<(BF+1))-1];
    logic [BF:0] prev_commit = '0;
    int          wr_count = 0;
    logic [BF:0] exp_ptr;
    logic [31:0] exp_acc;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int seed, input int i);
        return {32'(seed), 32'(i)};
    endfunction

    // Buffer mirror plus commit-time scoreboard comparison.
    always @(negedge clk156) begin
        sb_t         e;
        logic [BF:0] a;
        if (reset) begin
            prev_commit = '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] = wr_data;
                wr_count++;
            end
            if (commited_wr_address != prev_commit) begin
                if (sb_q.size() == 0) begin
                    check_val("commit_unexpected", 64'(commited_wr_address), 64'(prev_commit));
                end else begin
                    e = sb_q.pop_front();
                    check_val("commit_addr", 64'(commited_wr_address), 64'(e.commit));
                    check_val("accepted", 64'(accepted_frames), 64'(e.acc));
                    check_val("header", mem[e.hdr], {48'd0, e.len});
                    for (int i = 0; i < e.n; i++) begin
                        a = e.hdr + (BF+1)'(i + 1);
                        check_val("data", mem[a], pat(e.seed, i));
                    end
                end
                prev_commit = commited_wr_address;
            end
        end
    end

    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk156); #1;
            rx_axis.tvalid = 1'b0;
            rx_axis.tlast  = 1'b0;
            rx_axis.tuser  = 1'b0;
            rx_axis.tkeep  = 8'h00;
        end
    endtask

    task automatic send_frame(input int n, input logic [7:0] lkeep, input bit good,
                              input int seed, input bit expect_commit);
        sb_t ent;
        if (expect_commit) begin
            exp_acc    = exp_acc + 32'd1;
            ent.hdr    = exp_ptr;
            ent.len    = 16'(8 * (n - 1) + $countones(lkeep));
            ent.n      = n;
            ent.seed   = seed;
            ent.commit = exp_ptr + (BF+1)'(n + 1);
            ent.acc    = exp_acc;
            sb_q.push_back(ent);
            exp_ptr    = ent.commit;
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk156); #1;
            rx_axis.tvalid = 1'b1;
            rx_axis.tdata  = pat(seed, i);
            rx_axis.tkeep  = (i == n - 1) ? lkeep : 8'hFF;
            rx_axis.tlast  = (i == n - 1);
            rx_axis.tuser  = (i == n - 1) ? good : 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk156); #1;
        reset          = 1'b1;
        rx_axis.tvalid = 1'b0;
        rx_axis.tlast  = 1'b0;
        rx_axis.tuser  = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        reset   = 1'b0;
        exp_ptr = '0;
        exp_acc = 32'd0;
        sb_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_wr_en"},   64'(wr_en), 64'd0);
        check_val({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check_val({tag, "_wr_data"}, wr_data, 64'd0);
        check_val({tag, "_commit"},  64'(commited_wr_address), 64'd0);
        check_val({tag, "_acc"},     64'(accepted_frames), 64'd0);
        check_val({tag, "_drop"},    64'(dropped_frames), 64'd0);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            @(posedge clk156);
            k++;
        end
        #1;
        check_val("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        int wb;
        reset               = 1'b1;
        commited_rd_address = '0;
        rx_axis.tvalid      = 1'b0;
        rx_axis.tdata       = 64'd0;
        rx_axis.tkeep       = 8'h00;
        rx_axis.tlast       = 1'b0;
        rx_axis.tuser       = 1'b0;
        exp_ptr             = '0;
        exp_acc             = 32'd0;

        do_reset();
        check_zero("rst");

        // 64 B good frame: data 1..8, header 0, commit 9
        wb = wr_count;
        send_frame(8, 8'hFF, 1'b1, 32'h101, 1'b1);
        idle_gap(4);
        wait_drain(50);
        check_val("t1_writes", 64'(wr_count - wb), 64'd9);
        check_val("t1_drop", 64'(dropped_frames), 64'd0);

        // Partial frame cut by reset leaves no trace
        for (int i = 0; i < 4; i++) begin
            @(posedge clk156); #1;
            rx_axis.tvalid = 1'b1;
            rx_axis.tdata  = pat(32'hDEAD, i);
            rx_axis.tkeep  = 8'hFF;
            rx_axis.tlast  = 1'b0;
        end
        do_reset();
        check_zero("rst_mid");

        // 60 B frame
        send_frame(8, 8'h0F, 1'b1, 32'h202, 1'b1);
        idle_gap(4);
        wait_drain(50);
        check_val("t2_commit", 64'(commited_wr_address), 64'd9);

        // Bad frame then 16 B good frame
        do_reset();
        send_frame(5, 8'hFF, 1'b0, 32'h303, 1'b0);
        idle_gap(3);
        send_frame(2, 8'hFF, 1'b1, 32'h304, 1'b1);
        idle_gap(4);
        wait_drain(50);
        check_val("t3_drop", 64'(dropped_frames), 64'd1);
        check_val("t3_commit", 64'(commited_wr_address), 64'd3);

        // Buffer fills: third 190-beat frame dropped
        do_reset();
        send_frame(190, 8'hFF, 1'b1, 32'h401, 1'b1);
        idle_gap(3);
        send_frame(190, 8'hFF, 1'b1, 32'h402, 1'b1);
        idle_gap(3);
        send_frame(190, 8'hFF, 1'b1, 32'h403, 1'b0);
        idle_gap(4);
        wait_drain(50);
        check_val("t4_commit", 64'(commited_wr_address), 64'd382);
        check_val("t4_drop", 64'(dropped_frames), 64'd1);
        check_val("t4_acc", 64'(accepted_frames), 64'd2);

        // Oversized 192-beat frame
        do_reset();
        wb = wr_count;
        send_frame(192, 8'hFF, 1'b1, 32'h501, 1'b0);
        idle_gap(4);
        check_val("t5_writes", 64'(wr_count - wb), 64'd191);
        check_val("t5_drop", 64'(dropped_frames), 64'd1);
        check_val("t5_commit0", 64'(commited_wr_address), 64'd0);
        check_val("t5_acc0", 64'(accepted_frames), 64'd0);
        send_frame(8, 8'h07, 1'b1, 32'h502, 1'b1);
        idle_gap(4);
        wait_drain(50);
        check_val("t5_commit", 64'(commited_wr_address), 64'd9);

        // Inter-frame gap violation
        do_reset();
        send_frame(8, 8'hFF, 1'b1, 32'h601, 1'b1);
        idle_gap(1);
        send_frame(8, 8'hFF, 1'b1, 32'h602, 1'b0);
        idle_gap(3);
        send_frame(8, 8'h01, 1'b1, 32'h603, 1'b1);
        idle_gap(4);
        wait_drain(50);
        check_val("t6_drop", 64'(dropped_frames), 64'd1);
        check_val("t6_acc", 64'(accepted_frames), 64'd2);
        check_val("t6_commit", 64'(commited_wr_address), 64'd18);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
